// File: rtl/cheri_stkz_mq.sv
// Stack-zeroization engine: clears memory from an exclusive top down to an inclusive base.
// It keeps up to MAX_OUTST zero-stores in flight on the LSU request port. An interrupt either
// aborts the run or pauses it so that it can be resumed later.
module cheri_stkz_mq #(
    parameter int unsigned ZB        = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter bit          RESUME_EN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       start_top_i,
    input  logic [31:0]       start_base_i,
    input  logic              stop_i,
    input  logic              intr_i,
    input  logic              resume_i,
    output logic              active_o,
    output logic              paused_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       ptr_o,
    output logic [31:0]       base_o,
    output logic              lsu_req_o,
    input  logic              lsu_gnt_i,
    output logic [31:0]       lsu_addr_o,
    output logic              lsu_we_o,
    output logic [ZB-1:0]     lsu_be_o,
    output logic [8*ZB-1:0]   lsu_wdata_o,
    output logic              lsu_is_cap_o,
    input  logic              lsu_resp_valid_i,
    input  logic              lsu_resp_err_i
);

    localparam int unsigned     CntW      = $clog2(MAX_OUTST + 1);
    localparam logic [31:0]     Step      = 32'(ZB);
    localparam logic [31:0]     AlignMask = ~(Step - 32'd1);
    localparam logic [CntW-1:0] MaxCnt    = CntW'(MAX_OUTST);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain, StPaused} state_e;

    state_e          state_q, state_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [31:0]     issue_q, issue_d;
    logic [31:0]     base_q, base_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            pause_q, pause_d;  // current drain ends in PAUSED rather than IDLE

    logic [31:0] top_al, base_al;
    logic        start_ok, grant, resp, resp_err_ev;

    assign top_al      = start_top_i & AlignMask;
    assign base_al     = start_base_i & AlignMask;
    assign start_ok    = start_i && ((state_q == StIdle) || (state_q == StPaused)) &&
                         (top_al > base_al);

    // Request depends only on registered state so that grant never loops back into it.
    assign lsu_req_o   = (state_q == StActive) && (issue_q > base_q) && (outst_q < MaxCnt);
    assign lsu_addr_o  = issue_q - Step;
    assign grant       = lsu_req_o && lsu_gnt_i;
    // Stray responses with nothing outstanding are ignored.
    assign resp        = lsu_resp_valid_i && (outst_q != '0);
    assign resp_err_ev = resp && lsu_resp_err_i;

    assign lsu_we_o     = 1'b1;
    assign lsu_be_o     = '1;
    assign lsu_wdata_o  = '0;
    assign lsu_is_cap_o = (ZB == 8);

    assign active_o = (state_q != StIdle);
    assign paused_o = (state_q == StPaused);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign ptr_o    = ptr_q;
    assign base_o   = base_q;

    // Outstanding-store counter: a grant and a response in the same cycle cancel out.
    always_comb begin
        outst_d = outst_q;
        if (grant && !resp) begin
            outst_d = outst_q + CntOne;
        end else if (!grant && resp) begin
            outst_d = outst_q - CntOne;
        end
    end

    // Next-state logic for pointers, flags and FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        issue_d = issue_q;
        base_d  = base_q;
        err_d   = err_q;
        pause_d = pause_q;
        done_d  = 1'b0;

        if (resp) begin
            ptr_d = ptr_q - Step;
            if (lsu_resp_err_i) begin
                err_d = 1'b1;
            end
        end
        if (grant) begin
            issue_d = issue_q - Step;
        end

        if (start_ok) begin
            ptr_d   = top_al;
            issue_d = top_al;
            base_d  = base_al;
            err_d   = 1'b0;
            pause_d = 1'b0;
            state_d = StActive;
        end else begin
            unique case (state_q)
                StIdle: ;
                StActive: begin
                    if (resp_err_ev || stop_i) begin
                        pause_d = 1'b0;
                        state_d = StDrain;
                    end else if ((issue_q == base_q) && (outst_d == '0)) begin
                        // Completion beats a coincident interrupt.
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (intr_i) begin
                        pause_d = RESUME_EN;
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    // An error or stop during a pause-drain turns it into an abort.
                    if (resp_err_ev || stop_i) begin
                        pause_d = 1'b0;
                    end
                    if (outst_d == '0) begin
                        state_d = (pause_d) ? StPaused : StIdle;
                    end
                end
                StPaused: begin
                    if (stop_i) begin
                        state_d = StIdle;
                    end else if (resume_i && RESUME_EN) begin
                        state_d = StActive;
                    end
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            issue_q <= '0;
            base_q  <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            issue_q <= issue_d;
            base_q  <= base_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pause_q <= pause_d;
        end
    end

endmodule

// File: tb/tb_cheri_stkz_mq.sv
// Bench for cheri_stkz_mq: three instances (word/abort, word/resume, capability/abort)
// run directed scenarios then random traffic against a per-instance behavioural model.
module tb_cheri_stkz_mq;

    localparam int N = 3;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic        start[N], stop[N], intr[N], resume[N], gnt[N], rv[N], re[N];
    logic [31:0] top[N], bin[N];
    logic        active[N], paused[N], done[N], err[N], req[N], we[N], iscap[N];
    logic [31:0] ptr[N], bout[N], addr[N];
    logic [3:0]  be0, be1;
    logic [7:0]  be2;
    logic [31:0] wd0, wd1;
    logic [63:0] wd2;

    cheri_stkz_mq #(.ZB(4), .MAX_OUTST(2), .RESUME_EN(1'b0)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start[0]), .start_top_i(top[0]),
        .start_base_i(bin[0]), .stop_i(stop[0]), .intr_i(intr[0]), .resume_i(resume[0]),
        .active_o(active[0]), .paused_o(paused[0]), .done_o(done[0]), .err_o(err[0]),
        .ptr_o(ptr[0]), .base_o(bout[0]), .lsu_req_o(req[0]), .lsu_gnt_i(gnt[0]),
        .lsu_addr_o(addr[0]), .lsu_we_o(we[0]), .lsu_be_o(be0), .lsu_wdata_o(wd0),
        .lsu_is_cap_o(iscap[0]), .lsu_resp_valid_i(rv[0]), .lsu_resp_err_i(re[0]));

    cheri_stkz_mq #(.ZB(4), .MAX_OUTST(2), .RESUME_EN(1'b1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start[1]), .start_top_i(top[1]),
        .start_base_i(bin[1]), .stop_i(stop[1]), .intr_i(intr[1]), .resume_i(resume[1]),
        .active_o(active[1]), .paused_o(paused[1]), .done_o(done[1]), .err_o(err[1]),
        .ptr_o(ptr[1]), .base_o(bout[1]), .lsu_req_o(req[1]), .lsu_gnt_i(gnt[1]),
        .lsu_addr_o(addr[1]), .lsu_we_o(we[1]), .lsu_be_o(be1), .lsu_wdata_o(wd1),
        .lsu_is_cap_o(iscap[1]), .lsu_resp_valid_i(rv[1]), .lsu_resp_err_i(re[1]));

    cheri_stkz_mq #(.ZB(8), .MAX_OUTST(3), .RESUME_EN(1'b0)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start[2]), .start_top_i(top[2]),
        .start_base_i(bin[2]), .stop_i(stop[2]), .intr_i(intr[2]), .resume_i(resume[2]),
        .active_o(active[2]), .paused_o(paused[2]), .done_o(done[2]), .err_o(err[2]),
        .ptr_o(ptr[2]), .base_o(bout[2]), .lsu_req_o(req[2]), .lsu_gnt_i(gnt[2]),
        .lsu_addr_o(addr[2]), .lsu_we_o(we[2]), .lsu_be_o(be2), .lsu_wdata_o(wd2),
        .lsu_is_cap_o(iscap[2]), .lsu_resp_valid_i(rv[2]), .lsu_resp_err_i(re[2]));

    int nvec = 0;
    int nerr = 0;

    // Reference model: run mode (0 idle, 1 clearing, 2 draining, 3 paused), pointers and
    // number of stores still awaiting a response.
    int          m_mode[N], m_q[N], rsp_cnt[N], dn_cnt[N];
    bit          m_pause[N], m_err[N], m_done[N];
    logic [31:0] m_ptr[N], m_issue[N], m_base[N];
    int          gnt_pct[N], rsp_pct[N], err_pct[N], err_at[N];
    logic [31:0] glog[$];
    int          glog_d;

    function automatic logic [31:0] zbv(int d);
        return (d == 2) ? 32'd8 : 32'd4;
    endfunction

    function automatic int maxo(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic bit model_req(int d);
        return (m_mode[d] == 1) && (m_issue[d] > m_base[d]) && (m_q[d] < maxo(d));
    endfunction

    task automatic chk1(input string tag, input int d, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, d, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic step(input int d, input bit er);
        logic [31:0] zb, mask, ta, ba;
        bit grant, resp, errev, sok;
        zb    = zbv(d);
        mask  = ~(zb - 32'd1);
        ta    = top[d] & mask;
        ba    = bin[d] & mask;
        grant = er && gnt[d];
        resp  = rv[d] && (m_q[d] > 0);
        errev = resp && re[d];
        sok   = start[d] && ((m_mode[d] == 0) || (m_mode[d] == 3)) && (ta > ba);
        m_done[d] = 1'b0;
        if (resp) begin
            m_ptr[d] -= zb;
            rsp_cnt[d]++;
            if (re[d]) m_err[d] = 1'b1;
        end
        if (grant) m_issue[d] -= zb;
        m_q[d] = m_q[d] + int'(grant) - int'(resp);
        if (sok) begin
            m_ptr[d] = ta; m_issue[d] = ta; m_base[d] = ba;
            m_err[d] = 1'b0; m_pause[d] = 1'b0; m_mode[d] = 1; rsp_cnt[d] = 0;
        end else if (m_mode[d] == 1) begin
            if (errev || stop[d]) begin
                m_mode[d] = 2; m_pause[d] = 1'b0;
            end else if (m_issue[d] == m_base[d] && m_q[d] == 0) begin
                m_mode[d] = 0; m_done[d] = 1'b1;
            end else if (intr[d]) begin
                m_mode[d] = 2; m_pause[d] = (d == 1);
            end
        end else if (m_mode[d] == 2) begin
            if (errev || stop[d]) m_pause[d] = 1'b0;
            if (m_q[d] == 0) m_mode[d] = m_pause[d] ? 3 : 0;
        end else if (m_mode[d] == 3) begin
            if (stop[d]) m_mode[d] = 0;
            else if (resume[d] && d == 1) m_mode[d] = 1;
        end
    endtask

    // One clock: pick memory-side responses, check outputs mid-cycle, advance the model.
    task automatic cyc();
        bit er;
        for (int d = 0; d < N; d++) begin
            gnt[d] = ($urandom_range(99) < gnt_pct[d]);
            rv[d]  = (m_q[d] > 0) && ($urandom_range(99) < rsp_pct[d]);
            re[d]  = rv[d] && ((rsp_cnt[d] + 1 == err_at[d]) ||
                               ($urandom_range(99) < err_pct[d]));
        end
        @(negedge clk_i);
        for (int d = 0; d < N; d++) begin
            er = model_req(d);
            chk1("req", d, req[d], er);
            if (er) chk32("addr", d, addr[d], m_issue[d] - zbv(d));
            chk1("active", d, active[d], m_mode[d] != 0);
            chk1("paused", d, paused[d], m_mode[d] == 3);
            chk1("done", d, done[d], m_done[d]);
            chk1("err", d, err[d], m_err[d]);
            chk32("ptr", d, ptr[d], m_ptr[d]);
            chk32("base", d, bout[d], m_base[d]);
            if (d == glog_d && req[d] && gnt[d]) glog.push_back(addr[d]);
            if (done[d]) dn_cnt[d]++;
            step(d, er);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        for (int d = 0; d < N; d++) begin
            start[d] = 0; stop[d] = 0; intr[d] = 0; resume[d] = 0;
            gnt_pct[d] = 0; rsp_pct[d] = 0; err_pct[d] = 0; err_at[d] = 0;
        end
    endtask

    task automatic run_until_idle(input int d, input int lim);
        int n = 0;
        while (m_mode[d] != 0 && n < lim) begin
            cyc();
            n++;
        end
        if (m_mode[d] != 0) begin
            nvec++;
            nerr++;
            $error("FAIL timeout[%0d] observed=busy expected=idle", d);
        end
    endtask

    task automatic go(input int d, input logic [31:0] t, input logic [31:0] b);
        start[d] = 1; top[d] = t; bin[d] = b;
        cyc();
        start[d] = 0;
    endtask

    initial begin
        int dn;
        rst_ni = 1'b0;
        glog_d = 0;
        for (int d = 0; d < N; d++) begin
            top[d] = '0; bin[d] = '0; gnt[d] = 0; rv[d] = 0; re[d] = 0;
            m_mode[d] = 0; m_q[d] = 0; rsp_cnt[d] = 0; dn_cnt[d] = 0;
            m_pause[d] = 0; m_err[d] = 0; m_done[d] = 0;
            m_ptr[d] = '0; m_issue[d] = '0; m_base[d] = '0;
        end
        clr();
        repeat (2) @(negedge clk_i);
        for (int d = 0; d < N; d++) begin
            chk1("rst_req", d, req[d], 1'b0);
            chk1("rst_active", d, active[d], 1'b0);
            chk1("rst_done", d, done[d], 1'b0);
            chk1("rst_err", d, err[d], 1'b0);
            chk32("rst_ptr", d, ptr[d], 32'h0);
            chk32("rst_base", d, bout[d], 32'h0);
            chk1("we", d, we[d], 1'b1);
            chk1("is_cap", d, iscap[d], d == 2);
        end
        chk32("be0", 0, 32'(be0), 32'hf);
        chk32("be2", 2, 32'(be2), 32'hff);
        chk32("wdata0", 0, wd0, 32'h0);
        chk32("wdata2", 2, wd2[63:32] | wd2[31:0], 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Full word run with grant always and one-cycle responses.
        glog.delete();
        gnt_pct[0] = 100; rsp_pct[0] = 100;
        go(0, 32'h1010, 32'h1000);
        run_until_idle(0, 40);
        repeat (2) cyc();
        chk32("t1_nstores", 0, 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk32("t1_addr", 0, glog[i], 32'h100c - 32'(4 * i));
        chk32("t1_done", 0, 32'(dn_cnt[0]), 32'd1);
        chk32("t1_ptr", 0, ptr[0], 32'h1000);

        // Responses held off: at most two stores in flight.
        glog.delete();
        rsp_pct[0] = 0;
        go(0, 32'h1010, 32'h1000);
        repeat (4) cyc();
        chk1("t2_req", 0, req[0], 1'b0);
        chk32("t2_ngrant", 0, 32'(glog.size()), 32'd2);
        rsp_pct[0] = 100;
        run_until_idle(0, 40);
        repeat (2) cyc();

        // Stop with one store outstanding.
        glog.delete();
        dn = dn_cnt[0];
        rsp_pct[0] = 0;
        go(0, 32'h1010, 32'h1000);
        cyc();
        gnt_pct[0] = 0; stop[0] = 1;
        cyc();
        stop[0] = 0;
        chk1("t3_active", 0, active[0], 1'b1);
        chk1("t3_req", 0, req[0], 1'b0);
        rsp_pct[0] = 100;
        run_until_idle(0, 40);
        repeat (2) cyc();
        chk32("t3_ngrant", 0, 32'(glog.size()), 32'd1);
        chk32("t3_done", 0, 32'(dn_cnt[0]), 32'(dn));
        clr();

        // Pause on interrupt, then resume.
        glog_d = 1;
        go(1, 32'h1010, 32'h1000);
        gnt_pct[1] = 100; rsp_pct[1] = 100;
        repeat (2) cyc();
        gnt_pct[1] = 0;
        cyc();
        intr[1] = 1;
        cyc();
        intr[1] = 0;
        cyc();
        chk1("t4_paused", 1, paused[1], 1'b1);
        chk32("t4_ptr", 1, ptr[1], 32'h1008);
        glog.delete();
        resume[1] = 1; gnt_pct[1] = 100;
        cyc();
        resume[1] = 0;
        run_until_idle(1, 40);
        repeat (2) cyc();
        chk32("t4_next", 1, (glog.size() > 0) ? glog[0] : 32'hdeadbeef, 32'h1004);
        chk32("t4_done", 1, 32'(dn_cnt[1]), 32'd1);
        clr();

        // Bus error on the second response aborts; next start clears the flag.
        dn = dn_cnt[0];
        gnt_pct[0] = 100; rsp_pct[0] = 100; err_at[0] = 2;
        go(0, 32'h1010, 32'h1000);
        run_until_idle(0, 40);
        cyc();
        chk1("t5_err", 0, err[0], 1'b1);
        chk32("t5_done", 0, 32'(dn_cnt[0]), 32'(dn));
        err_at[0] = 0;
        go(0, 32'h1008, 32'h1000);
        chk1("t5_errclr", 0, err[0], 1'b0);
        run_until_idle(0, 40);
        clr();

        // Capability granule with unaligned bounds, then an empty region.
        glog_d = 2;
        glog.delete();
        gnt_pct[2] = 100; rsp_pct[2] = 100;
        go(2, 32'h2017, 32'h2001);
        chk32("t6_base", 2, bout[2], 32'h2000);
        chk32("t6_ptr", 2, ptr[2], 32'h2010);
        run_until_idle(2, 40);
        repeat (2) cyc();
        chk32("t6_nstores", 2, 32'(glog.size()), 32'd2);
        chk32("t6_a0", 2, (glog.size() > 0) ? glog[0] : 32'hdeadbeef, 32'h2008);
        chk32("t6_a1", 2, (glog.size() > 1) ? glog[1] : 32'hdeadbeef, 32'h2000);
        go(2, 32'h2004, 32'h2001);
        chk1("t6_ignored", 2, active[2], 1'b0);
        chk32("t6_base_hold", 2, bout[2], 32'h2000);
        clr();

        // Random traffic on all three instances.
        glog_d = -1;
        for (int d = 0; d < N; d++) begin
            gnt_pct[d] = 70; rsp_pct[d] = 60; err_pct[d] = 3;
        end
        repeat (3000) begin
            for (int d = 0; d < N; d++) begin
                start[d] = ((m_mode[d] == 0 || m_mode[d] == 3) && $urandom_range(99) < 15);
                top[d]   = 32'h3000 + 32'($urandom_range(0, 60));
                bin[d]   = 32'h3000 + 32'($urandom_range(0, 60));
                stop[d]   = ($urandom_range(99) < 2);
                intr[d]   = ($urandom_range(99) < 4);
                resume[d] = ($urandom_range(99) < 25);
            end
            cyc();
        end
        clr();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
